operand_extender: RTL and testbench
===================================

# operand_extender

Parametrised, handshaked operand extension stage between instruction decode and the ALU/address path. Accepts an IN_W-bit immediate/address field plus a per-transaction mode, produces an OUT_W-bit extended operand (zero-extend, sign-extend, sign-extend-and-shift, or upper-load). A 2-entry output buffer decouples producer and consumer with full throughput and a registered `in_ready`.

## Interface
Parameters:
- IN_W, 11, width of incoming operand field
- OUT_W, 16, width of extended operand; must satisfy OUT_W >= IN_W + SHAMT (elaboration-time check, no runtime truncation)
- SHAMT, 1, left-shift amount applied in mode 2

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  producer has a transaction
- in_ready  out  1  block can accept; registered
- in_data  in  IN_W  operand field
- in_mode  in  2  0 zero-ext, 1 sign-ext, 2 sign-ext then << SHAMT, 3 upper-load
- out_valid  out  1  out_data holds a valid result
- out_ready  in  1  consumer accepts
- out_data  out  OUT_W  extended operand
- out_count  out  2  buffer occupancy (0..2)

## Operation
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready at a rising edge.
- Extension is computed combinationally from in_data/in_mode and written into the buffer at accept; buffer stores OUT_W-bit results only.
- Mode 0: {(OUT_W-IN_W) zeros, in_data}.
- Mode 1: {(OUT_W-IN_W) copies of in_data[IN_W-1], in_data}.
- Mode 2: mode-1 result shifted left SHAMT, zeros into LSBs; no bits lost given the width rule.
- Mode 3: in_data placed in out_data[OUT_W-1 -: IN_W], lower OUT_W-IN_W bits zero.
- Buffer: 2-entry FIFO, strict order preserved. out_data always presents head entry; undefined-free: when empty, out_data holds last popped value (0 after reset).
- Occupancy update per edge: push only +1, pop only -1, push and pop together unchanged.
- in_ready = (count < 2) computed from next-state and registered, so it is high in the cycle after any edge that leaves count < 2.
- Push when count == 2 impossible (in_ready low); in_valid with in_ready low is ignored, producer must hold data.
- Pop when empty impossible (out_valid low); out_ready while empty ignored.
- Reset mid-operation: all buffered entries discarded, no partial output; takes priority over simultaneous push/pop.

## Timing
- Reset values: in_ready 1, out_valid 0, out_data 0, out_count 0.
- Latency: transaction accepted at edge N is on out_data with out_valid high after edge N (visible cycle N+1); no combinational path in_* -> out_*.
- Throughput: 1 transaction/cycle sustained with out_ready held high (count oscillates 0/1 or stays 1).
- Backpressure: out_ready low with continuous in_valid fills 2 entries; in_ready drops after the edge that makes count 2. First out_ready-high edge pops one entry and in_ready returns high in the following cycle.
- out_data/out_valid change only on clock edges; stable while out_valid && !out_ready.

## Test plan
- Reset, then defaults (IN_W=11, OUT_W=16, SHAMT=1): check in_ready=1, out_valid=0, out_data=0x0000, out_count=0.
- Modes with out_ready=1: 0x400 mode 1 -> 0xFC00; 0x400 mode 0 -> 0x0400; 0x7FF mode 2 -> 0xFFFE; 0x001 mode 3 -> 0x0020; each out_valid exactly one cycle after accept, back-to-back sequence yields 4 outputs in 4 consecutive cycles.
- Backpressure: out_ready=0, offer 0x001,0x002,0x003 mode 0 continuously -> first two accepted, in_ready low, out_count=2, out_data=0x0001 stable; raise out_ready -> outputs 0x0001,0x0002,0x0003 in order, 0x003 accepted only after in_ready reasserts.
- Simultaneous push/pop at count=1 for 10 cycles -> out_count stays 1, no drops/duplicates (scoreboard compares order).
- Reset asserted with count=2 and in_valid/out_ready both high -> next cycle out_valid=0, out_count=0, in_ready=1, neither pending item ever emitted.
- Random valid/ready toggling, 1000 transactions, random modes -> scoreboard matches reference model bit-exact, out_data stable while stalled.

Source files
------------

// File: rtl/operand_extender_if.sv
// Handshake bundle for the operand extension stage: producer side
// (in_*) and consumer side (out_*), plus the buffer occupancy.
interface operand_extender_if #(
   parameter int IN_W  = 11,
   parameter int OUT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_data;
   logic [1:0]       in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic [1:0]       out_count;

   // Producer/consumer environment drives requests and observes results.
   modport master (
      output in_valid, in_data, in_mode, out_ready,
      input  in_ready, out_valid, out_data, out_count
   );

   // The extension stage itself.
   modport slave (
      input  in_valid, in_data, in_mode, out_ready,
      output in_ready, out_valid, out_data, out_count
   );
endinterface

// File: rtl/operand_extender.sv
// Operand extension stage: zero-extend, sign-extend, sign-extend-and-shift
// or upper-load an IN_W-bit field to OUT_W bits, decoupled from the consumer
// by a 2-entry in-order buffer. The head entry is a register that drives
// out_data directly, so there is no combinational path from in_* to out_*.
module operand_extender #(
   parameter int IN_W  = 11,
   parameter int OUT_W = 16,
   parameter int SHAMT = 1
) (
   input  logic clk,
   input  logic reset,
   operand_extender_if.slave bus
);

   if (OUT_W < IN_W + SHAMT) begin : g_width_check
      $error("operand_extender: OUT_W must be >= IN_W + SHAMT");
   end

   // Mode 0 zero-extend, 1 sign-extend, 2 sign-extend then shift, 3 upper-load.
   function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] d,
                                               input logic [1:0]      m);
      logic signed [IN_W-1:0]  sd;
      logic signed [OUT_W-1:0] sx;
      logic [OUT_W-1:0]        r;
      sd = d;
      sx = OUT_W'(sd);
      case (m)
         2'd0:    r = OUT_W'(d);
         2'd1:    r = sx;
         2'd2:    r = sx <<< SHAMT;
         default: r = OUT_W'(d) << (OUT_W - IN_W);
      endcase
      return r;
   endfunction

   logic [1:0]       count_q;
   logic [1:0]       count_d;
   logic             in_ready_q;
   logic [OUT_W-1:0] head_p1;
   logic [OUT_W-1:0] tail_p1;
   logic [OUT_W-1:0] ext_p0;
   logic             push;
   logic             pop;
   logic             vld_p1;

   assign ext_p0 = extend(bus.in_data, bus.in_mode);
   assign vld_p1 = (count_q != 2'd0);
   assign push   = bus.in_valid && in_ready_q;
   assign pop    = vld_p1 && bus.out_ready;

   // Occupancy next-state: push +1, pop -1, both together unchanged.
   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // ---- stage p0 -> p1: accept extended operand into the buffer ----

   // Control registers; in_ready is precomputed from the next occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q    <= 2'd0;
         in_ready_q <= 1'b1;
      end else begin
         count_q    <= count_d;
         in_ready_q <= (count_d < 2'd2);
      end
   end

   // Head entry drives out_data; it keeps the last popped value when empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         head_p1 <= '0;
      end else if (pop) begin
         if (count_q == 2'd2)
            head_p1 <= tail_p1;
         else if (push)
            head_p1 <= ext_p0;
      end else if (push && count_q == 2'd0) begin
         head_p1 <= ext_p0;
      end
   end

   // Second entry, only written when a push lands behind a held head.
   always_ff @(posedge clk) begin
      if (push && !pop && count_q == 2'd1)
         tail_p1 <= ext_p0;
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = vld_p1;
   assign bus.out_data  = head_p1;
   assign bus.out_count = count_q;

endmodule

// File: tb/tb_operand_extender.sv
// Directed and randomized checks for operand_extender at IN_W=11, OUT_W=16,
// SHAMT=1. Inputs change and outputs are sampled 1 time unit after each
// rising edge.
module tb_operand_extender;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   operand_extender_if #(.IN_W(11), .OUT_W(16)) bus ();

   operand_extender #(.IN_W(11), .OUT_W(16), .SHAMT(1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Independent reference for the fixed 11 -> 16 bit configuration.
   function automatic logic [15:0] ref_ext(input logic [10:0] d, input logic [1:0] m);
      case (m)
         2'd0:    return {5'b00000, d};
         2'd1:    return {{5{d[10]}}, d};
         2'd2:    return {{4{d[10]}}, d, 1'b0};
         default: return {d, 5'b00000};
      endcase
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_mode = '0; bus.out_ready = 1'b0;
      tick(); tick();
      reset = 1'b0;
      tick();
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
      n_cmp++; if (bus.out_data !== 16'h0000) begin n_err++; $display("FAIL reset_out_data got %h want 0000", bus.out_data); end
      n_cmp++; if (bus.out_count !== 2'd0) begin n_err++; $display("FAIL reset_out_count got %0d want 0", bus.out_count); end
   endtask

   task automatic test_modes();
      logic [10:0] d [4] = '{11'h400, 11'h400, 11'h7FF, 11'h001};
      logic [1:0]  m [4] = '{2'd1, 2'd0, 2'd2, 2'd3};
      logic [15:0] e [4] = '{16'hFC00, 16'h0400, 16'hFFFE, 16'h0020};
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1; bus.in_data = d[i]; bus.in_mode = m[i];
         tick();
         n_cmp++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== e[i] || bus.out_count !== 2'd1)
         begin
            n_err++;
            $display("FAIL mode_vec%0d got v=%b d=%h c=%0d want v=1 d=%h c=1",
                     i, bus.out_valid, bus.out_data, bus.out_count, e[i]);
         end
      end
      bus.in_valid = 1'b0;
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.out_count !== 2'd0 || bus.out_data !== 16'h0020) begin
         n_err++;
         $display("FAIL mode_drain got v=%b c=%0d d=%h want v=0 c=0 d=0020",
                  bus.out_valid, bus.out_count, bus.out_data);
      end
   endtask

   task automatic test_backpressure();
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.in_mode = 2'd0; bus.in_data = 11'h001;
      tick();
      n_cmp++; if (bus.out_count !== 2'd1 || bus.out_data !== 16'h0001 || bus.in_ready !== 1'b1) begin
         n_err++; $display("FAIL bp_first got c=%0d d=%h r=%b want c=1 d=0001 r=1", bus.out_count, bus.out_data, bus.in_ready); end
      bus.in_data = 11'h002;
      tick();
      n_cmp++; if (bus.out_count !== 2'd2 || bus.in_ready !== 1'b0 || bus.out_data !== 16'h0001) begin
         n_err++; $display("FAIL bp_full got c=%0d r=%b d=%h want c=2 r=0 d=0001", bus.out_count, bus.in_ready, bus.out_data); end
      bus.in_data = 11'h003;
      tick();
      n_cmp++; if (bus.out_count !== 2'd2 || bus.in_ready !== 1'b0 || bus.out_data !== 16'h0001 || bus.out_valid !== 1'b1) begin
         n_err++; $display("FAIL bp_stall got c=%0d r=%b d=%h v=%b want c=2 r=0 d=0001 v=1", bus.out_count, bus.in_ready, bus.out_data, bus.out_valid); end
      bus.out_ready = 1'b1;
      tick();
      n_cmp++; if (bus.out_count !== 2'd1 || bus.in_ready !== 1'b1 || bus.out_data !== 16'h0002) begin
         n_err++; $display("FAIL bp_release got c=%0d r=%b d=%h want c=1 r=1 d=0002", bus.out_count, bus.in_ready, bus.out_data); end
      tick();
      n_cmp++; if (bus.out_count !== 2'd1 || bus.out_data !== 16'h0003) begin
         n_err++; $display("FAIL bp_third got c=%0d d=%h want c=1 d=0003", bus.out_count, bus.out_data); end
      bus.in_valid = 1'b0;
      tick();
      n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_count !== 2'd0 || bus.out_data !== 16'h0003) begin
         n_err++; $display("FAIL bp_empty_hold got v=%b c=%0d d=%h want v=0 c=0 d=0003", bus.out_valid, bus.out_count, bus.out_data); end
   endtask

   task automatic test_back_to_back();
      bus.out_ready = 1'b1; bus.in_mode = 2'd0;
      bus.in_valid = 1'b1; bus.in_data = 11'h010;
      tick();
      for (int i = 0; i < 10; i++) begin
         bus.in_data = 11'(11'h011 + i);
         tick();
         n_cmp++;
         if (bus.out_count !== 2'd1 || bus.out_data !== 16'(16'h0011 + i) || bus.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_cyc%0d got c=%0d d=%h want c=1 d=%h", i, bus.out_count, bus.out_data, 16'(16'h0011 + i));
         end
      end
      bus.in_valid = 1'b0;
      tick();
      n_cmp++; if (bus.out_count !== 2'd0) begin n_err++; $display("FAIL b2b_drain got c=%0d want 0", bus.out_count); end
   endtask

   task automatic test_reset_mid();
      logic leaked;
      bus.out_ready = 1'b0; bus.in_mode = 2'd0;
      bus.in_valid = 1'b1; bus.in_data = 11'h0AA;
      tick();
      bus.in_data = 11'h0BB;
      tick();
      n_cmp++; if (bus.out_count !== 2'd2) begin n_err++; $display("FAIL rstmid_fill got c=%0d want 2", bus.out_count); end
      bus.in_data = 11'h0CC; bus.out_ready = 1'b1; reset = 1'b1;
      tick();
      reset = 1'b0; bus.in_valid = 1'b0;
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.out_count !== 2'd0 || bus.in_ready !== 1'b1 || bus.out_data !== 16'h0000) begin
         n_err++;
         $display("FAIL rstmid_state got v=%b c=%0d r=%b d=%h want v=0 c=0 r=1 d=0000",
                  bus.out_valid, bus.out_count, bus.in_ready, bus.out_data);
      end
      leaked = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.out_valid !== 1'b0) leaked = 1'b1;
      end
      n_cmp++; if (leaked) begin n_err++; $display("FAIL rstmid_leak got out_valid=1 want 0 after reset"); end
   endtask

   task automatic test_random();
      logic [15:0] q[$];
      logic [15:0] exp_v;
      logic [15:0] prev_d;
      logic        acc, pop, stall, acc_last;
      int          sent, recv, cyc;
      sent = 0; recv = 0; cyc = 0; acc_last = 1'b0;
      bus.in_valid = 1'b0;
      while (recv < 1000 && cyc < 20000) begin
         if (!bus.in_valid || acc_last) begin
            if (sent < 1000 && $urandom_range(0, 3) != 0) begin
               bus.in_valid = 1'b1;
               bus.in_data  = 11'($urandom_range(0, 2047));
               bus.in_mode  = 2'($urandom_range(0, 3));
            end else begin
               bus.in_valid = 1'b0;
            end
         end
         bus.out_ready = ($urandom_range(0, 2) != 0);
         acc   = bus.in_valid && bus.in_ready;
         pop   = bus.out_valid && bus.out_ready;
         stall = bus.out_valid && !bus.out_ready;
         prev_d = bus.out_data;
         if (pop) begin
            n_cmp++;
            if (q.size() == 0) begin
               n_err++; $display("FAIL rnd_spurious got d=%h with empty reference queue", bus.out_data);
            end else begin
               exp_v = q.pop_front();
               if (bus.out_data !== exp_v) begin
                  n_err++; $display("FAIL rnd_data#%0d got %h want %h", recv, bus.out_data, exp_v);
               end
            end
            recv++;
         end
         if (acc) begin
            q.push_back(ref_ext(bus.in_data, bus.in_mode));
            sent++;
         end
         acc_last = acc;
         tick();
         cyc++;
         if (stall && (bus.out_data !== prev_d || bus.out_valid !== 1'b1)) begin
            n_cmp++; n_err++;
            $display("FAIL rnd_stall got d=%h v=%b want d=%h v=1", bus.out_data, bus.out_valid, prev_d);
         end
         if (bus.out_count !== 2'(q.size())) begin
            n_cmp++; n_err++;
            $display("FAIL rnd_count got %0d want %0d", bus.out_count, q.size());
         end
      end
      bus.in_valid = 1'b0;
      n_cmp++;
      if (recv != 1000) begin n_err++; $display("FAIL rnd_timeout got %0d outputs want 1000", recv); end
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_mode = '0; bus.out_ready = 1'b0;
      test_reset();
      test_modes();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
